// File: rtl/scc_run_pkg.sv
// Shared types for the core run controller: FSM encoding and exit status codes.
package scc_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3
  } run_state_e;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_HALT = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  // Error outranks halt, halt outranks timeout when they land together.
  function automatic logic [1:0] exit_status(input logic err, input logic halt, input logic tmo);
    if (err)       return ST_ERR;
    else if (halt) return ST_HALT;
    else if (tmo)  return ST_TMO;
    else           return ST_NONE;
  endfunction

endpackage

// File: rtl/scc_run_counter.sv
// Loadable down-counter for fixed-length phases plus a saturating up-counter
// with clear/enable; up_nxt exposes the post-update value for compare logic.
module scc_run_counter #(
  parameter int DN_W = 2,
  parameter int UP_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dn_load,
  input  logic [DN_W-1:0] dn_val,
  input  logic            dn_en,
  output logic            dn_zero,
  input  logic            up_clr,
  input  logic            up_en,
  output logic [UP_W-1:0] up_cnt,
  output logic [UP_W-1:0] up_nxt
);

  logic [DN_W-1:0] dn_cnt_q, dn_cnt_d;
  logic [UP_W-1:0] up_cnt_q;

  assign dn_zero = (dn_cnt_q == '0);
  assign up_cnt  = up_cnt_q;

  always_comb begin
    dn_cnt_d = dn_cnt_q;
    if (dn_load)               dn_cnt_d = dn_val;
    else if (dn_en && !dn_zero) dn_cnt_d = dn_cnt_q - 1'b1;
  end

  always_comb begin
    up_nxt = up_cnt_q;
    if (up_clr)                          up_nxt = '0;
    else if (up_en && (up_cnt_q != '1))  up_nxt = up_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dn_cnt_q <= '0;
      up_cnt_q <= '0;
    end else begin
      dn_cnt_q <= dn_cnt_d;
      up_cnt_q <= up_nxt;
    end
  end

endmodule

// File: rtl/scc_run_ctrl.sv
// Run controller: sequences core reset, gates core clock (free-run or single-step)
// and ends the run on halt, error or cycle-budget timeout with sticky status.
module scc_run_ctrl
  import scc_run_pkg::*;
#(
  parameter int NUM_CORES  = 1,
  parameter int RST_CYCLES = 3,
  parameter int MAX_CYCLES = 30,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   step_mode,
  input  logic                   step_req,
  input  logic [NUM_CORES-1:0]   halt_f,
  input  logic [2*NUM_CORES-1:0] err_bits,
  output logic                   core_rst,
  output logic                   core_clk_en,
  output logic                   done,
  output logic [1:0]             status,
  output logic [2*NUM_CORES-1:0] err_latched,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [2:0]             state
);

  localparam int               RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LOAD = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam logic             TMO_EN   = (MAX_CYCLES != 0);

  run_state_e               state_q, state_d;
  logic                     core_rst_q, core_rst_d;
  logic                     clk_en_q, clk_en_d;
  logic                     done_q, done_d;
  logic [1:0]               status_q, status_d;
  logic [2*NUM_CORES-1:0]   err_lat_q, err_lat_d;
  logic [NUM_CORES-1:0]     halt_q;
  logic [2*NUM_CORES-1:0]   err_q;

  logic             go_reset, dn_zero, cnt_en, cnt_clr;
  logic             ex_halt, ex_err, ex_tmo;
  logic [CNT_W-1:0] cnt_nxt;

  assign go_reset = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign cnt_en   = (state_q == S_RUN) && clk_en_q;
  assign cnt_clr  = abort || go_reset;

  // Exit decisions use the once-registered core flags and the post-increment count.
  assign ex_halt = &halt_q;
  assign ex_err  = |err_q;
  assign ex_tmo  = TMO_EN && (cnt_nxt == MAX_CNT);

  scc_run_counter #(
    .DN_W (RW),
    .UP_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .dn_load (go_reset),
    .dn_val  (RST_LOAD),
    .dn_en   (state_q == S_RESET),
    .dn_zero (dn_zero),
    .up_clr  (cnt_clr),
    .up_en   (cnt_en),
    .up_cnt  (cycle_count),
    .up_nxt  (cnt_nxt)
  );

  always_comb begin
    state_d    = state_q;
    core_rst_d = core_rst_q;
    clk_en_d   = clk_en_q;
    done_d     = done_q;
    status_d   = status_q;
    err_lat_d  = err_lat_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RESET;
          core_rst_d = 1'b1;
          clk_en_d   = 1'b1;
          done_d     = 1'b0;
          status_d   = ST_NONE;
          err_lat_d  = '0;
        end
      end
      S_RESET: begin
        if (dn_zero) begin
          state_d    = S_RUN;
          core_rst_d = 1'b0;
          clk_en_d   = step_mode ? step_req : 1'b1;
        end
      end
      S_RUN: begin
        if (ex_err || ex_halt || ex_tmo) begin
          state_d   = S_DONE;
          clk_en_d  = 1'b0;
          done_d    = 1'b1;
          status_d  = exit_status(ex_err, ex_halt, ex_tmo);
          err_lat_d = err_q;
        end else begin
          clk_en_d  = step_mode ? step_req : 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        core_rst_d = 1'b1;
        clk_en_d   = 1'b0;
      end
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      core_rst_d = 1'b1;
      clk_en_d   = 1'b0;
      done_d     = 1'b0;
      status_d   = ST_NONE;
      err_lat_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      core_rst_q <= 1'b1;
      clk_en_q   <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= ST_NONE;
      err_lat_q  <= '0;
      halt_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      clk_en_q   <= clk_en_d;
      done_q     <= done_d;
      status_q   <= status_d;
      err_lat_q  <= err_lat_d;
      halt_q     <= halt_f;
      err_q      <= err_bits;
    end
  end

  assign core_rst    = core_rst_q;
  assign core_clk_en = clk_en_q;
  assign done        = done_q;
  assign status      = status_q;
  assign err_latched = err_lat_q;
  assign state       = state_q;

endmodule

// File: tb/tb_scc_run_ctrl.sv
// Bench for scc_run_ctrl: directed runs; expected end-of-run results are queued
// at issue time and checked by a monitor whenever done rises.
module tb_scc_run_ctrl;

  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, step_mode, step_req;
  logic [NC-1:0]   halt_f;
  logic [2*NC-1:0] err_bits;
  logic          core_rst, core_clk_en, done;
  logic [1:0]    status;
  logic [2*NC-1:0] err_latched;
  logic [15:0]   cycle_count;
  logic [2:0]    state;

  typedef struct {
    logic [1:0]      st;
    logic [2*NC-1:0] el;
    logic [15:0]     cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   en_run = 0;
  logic done_prev = 1'b0;

  scc_run_ctrl #(
    .NUM_CORES  (NC),
    .RST_CYCLES (3),
    .MAX_CYCLES (30),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .step_mode   (step_mode),
    .step_req    (step_req),
    .halt_f      (halt_f),
    .err_bits    (err_bits),
    .core_rst    (core_rst),
    .core_clk_en (core_clk_en),
    .done        (done),
    .status      (status),
    .err_latched (err_latched),
    .cycle_count (cycle_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_run();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called right after the start edge: three reset cycles, then RUN.
  task automatic chk_reset_seq();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstseq_core_rst", core_rst, (i < 3) ? 1 : 0);
      chk("rstseq_state", state, (i < 3) ? 1 : 2);
      chk("rstseq_clk_en", core_clk_en, 1);
    end
    chk("rstseq_cnt", cycle_count, 0);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_done: no done within %0d cycles", max);
    end
  endtask

  // Monitor: track enabled cycles since core reset dropped; score each done rise.
  always @(negedge clk) begin
    exp_t e;
    if (core_rst === 1'b1) en_run = 0;
    else if (core_clk_en === 1'b1) en_run++;
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done: status %0h, none expected", status);
      end else begin
        e = sb.pop_front();
        chk("sb_status", status, e.st);
        chk("sb_err_latched", err_latched, e.el);
        chk("sb_cycle_count", cycle_count, e.cnt);
        chk("sb_en_cycles", en_run, e.cnt);
        chk("sb_clk_en_off", core_clk_en, 0);
        chk("sb_state_done", state, 3);
      end
    end
    done_prev = done;
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    halt_f = '0; err_bits = '0;
    tickn(2);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_clk_en", core_clk_en, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_err_latched", err_latched, 0);
    chk("rst_cnt", cycle_count, 0);
    tick();
    rst = 1'b1;

    // Timeout run: 30 enabled cycles
    sb.push_back('{st: 2'b11, el: '0, cnt: 16'd30});
    start_run();
    chk_reset_seq();
    wait_done(60);

    // Core0 halts at run cycle 5, core1 at 9; exit two edges later -> count 11
    sb.push_back('{st: 2'b01, el: '0, cnt: 16'd11});
    start_run();
    tickn(3);
    tickn(5);
    halt_f = 2'b01;
    tickn(4);
    halt_f = 2'b11;
    wait_done(20);
    @(negedge clk);
    chk("halt_clk_en_held_off", core_clk_en, 0);
    tick();
    halt_f = '0;

    // Error and halt together: error wins
    sb.push_back('{st: 2'b10, el: 4'b0010, cnt: 16'd4});
    start_run();
    tickn(3);
    tickn(2);
    err_bits = 4'b0010;
    halt_f   = 2'b11;
    wait_done(20);
    tick();
    err_bits = '0;
    halt_f   = '0;

    // Single-step: three spaced pulses, then a two-cycle hold, then free-run
    step_mode = 1'b1;
    start_run();
    tickn(3);
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      tickn(3);
    end
    chk("step_cnt3", cycle_count, 3);
    chk("step_en3", en_run, 3);
    chk("step_state_run", state, 2);
    chk("step_clk_en_off", core_clk_en, 0);
    chk("step_not_done", done, 0);
    step_req = 1'b1;
    tickn(2);
    step_req = 1'b0;
    tickn(2);
    chk("step_cnt5", cycle_count, 5);
    chk("step_en5", en_run, 5);
    sb.push_back('{st: 2'b11, el: '0, cnt: 16'd30});
    step_mode = 1'b0;
    wait_done(60);

    // Abort mid-run, then a fresh start
    start_run();
    tickn(3);
    tickn(5);
    chk("abort_pre_cnt", cycle_count, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_state", state, 0);
    chk("abort_core_rst", core_rst, 1);
    chk("abort_clk_en", core_clk_en, 0);
    chk("abort_status", status, 0);
    chk("abort_cnt", cycle_count, 0);
    sb.push_back('{st: 2'b11, el: '0, cnt: 16'd30});
    start_run();
    chk_reset_seq();
    wait_done(60);
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_over_start_state", state, 0);
    chk("abort_over_start_done", done, 0);
    chk("abort_over_start_status", status, 0);

    // Start ignored in RUN; sync reset mid-run clears everything
    start_run();
    tickn(3);
    tickn(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("start_in_run_state", state, 2);
    chk("start_in_run_cnt", cycle_count, 5);
    chk("start_in_run_core_rst", core_rst, 0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", state, 0);
    chk("midrst_core_rst", core_rst, 1);
    chk("midrst_clk_en", core_clk_en, 0);
    chk("midrst_status", status, 0);
    chk("midrst_cnt", cycle_count, 0);
    chk("midrst_done", done, 0);

    tickn(2);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
